ifetch_prefetch_buf: RTL and testbench
======================================

Name: ifetch_prefetch_buf

Overview:
- Upstream neighbour of the fetch stage: sits between the instruction-memory bus and the fetch/decode pipeline register.
- Issues sequential word fetches ahead of the core and buffers in-order responses in a small FIFO.
- Presents {instr, pc, err} to the consumer with a valid/ready handshake.
- On a control-flow redirect (jal/jalr/taken branch), flushes the buffer, discards in-flight responses and restarts at the new PC.

Parameters:
- DEPTH, 2, FIFO entries and maximum outstanding requests; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- redirect_i  in  1  one-cycle pulse: flush and restart fetching at redirect_addr_i.
- redirect_addr_i  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- ready_i  in  1  consumer accepts the head entry this cycle.
- instr_valid_o  out  1  head entry is valid.
- instr_o  out  32  instruction word of the head entry.
- instr_pc_o  out  32  PC of the head entry.
- instr_err_o  out  1  bus error flag of the head entry.
- bus_req_o  out  1  fetch request.
- bus_addr_o  out  32  fetch address, always word aligned.
- bus_gnt_i  in  1  request accepted this cycle.
- bus_rvalid_i  in  1  response valid; responses are in order, at least 1 cycle after grant.
- bus_rdata_i  in  32  response data.
- bus_err_i  in  1  response error, qualified by bus_rvalid_i.

Behaviour:
- Reset values:
  - bus_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_err_o=0.
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=RUN.
- Counters:
  - outstanding: granted but not yet responded, width clog2(DEPTH)+1.
  - discard: responses still to be dropped.
  - count: FIFO occupancy.
- Request rule:
  - bus_req_o=1 when state==RUN and (count+outstanding)<DEPTH, or when a request is pending (see hold rule).
  - bus_addr_o=fetch_pc.
  - On bus_req_o&&bus_gnt_i: fetch_pc+=4 (32-bit wrap from 0xFFFF_FFFC to 0), outstanding+=1, and the request PC is pushed into a PC-tag queue.
- Hold rule:
  - Once bus_req_o is asserted, it and bus_addr_o stay stable until granted, even across a redirect.
  - A grant that lands on a stale request increments discard instead of being tracked as live.
- Response rule: on bus_rvalid_i, outstanding-=1, then:
  - if discard>0: drop the response, discard-=1;
  - else push {bus_err_i, tag_pc, bus_rdata_i} into the FIFO.
  - The credit check guarantees the FIFO is never pushed when full.
- Output handshake:
  - Head entry is transferred when instr_valid_o&&ready_i.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Outputs hold stable while instr_valid_o&&!ready_i.
- Latency without bypass: grant -> rvalid -> instr_valid_o one cycle after rvalid.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO cleared; fetch_pc=redirect_addr_i&~3.
  - discard = outstanding, adjusted for the same-cycle rvalid (-1) and same-cycle grant (+1).
  - A same-cycle rvalid is dropped.
  - The first new request may be issued in the next cycle.
- States:
  - RUN: normal operation.
  - ERR_HOLD: entered when an error response is pushed; no new requests are issued; in-flight responses are still accepted.
  - ERR_HOLD -> RUN only on redirect_i.
- Reset mid-operation clears all state asynchronously. The bus is reset by the same rstn, so no stale responses arrive.

Optional Feature:
- Macro: IFB_BYPASS_EN.
- Defined: when the FIFO is empty, discard==0 and bus_rvalid_i=1, the response drives instr_*_o combinationally in the same cycle.
  - If ready_i is also 1, the entry is consumed without being written to the FIFO.
  - Otherwise it is written to the FIFO as normal.
- Undefined: every response passes through the FIFO; minimum 1-cycle rvalid-to-valid latency.

Decomposition:
- Shared package holds:
  - constants INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0013;
  - a typedef for the FIFO entry {err, pc[31:0], instr[31:0]};
  - the state enum {RUN, ERR_HOLD}.
- One natural sub-module: ifb_fifo, a synchronous DEPTH-entry FIFO with push/pop/flush and full/empty/count outputs.
  - Instantiate it for the entry FIFO and again for the PC-tag queue.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, ready=1: bus_addr sequence 0,4,8,C; instr_pc_o 0,4,8,C on consecutive cycles after the initial latency.
- ready=0, DEPTH=2: after 2 responses, count=2 and bus_req_o=0; one cycle of ready=1 pops PC 0 and exactly one new request is issued.
- 2 requests outstanding (PC 0x10, 0x14), redirect to 0x103: both responses dropped; next bus_addr=0x100; first instr_pc_o=0x100.
- Redirect in the same cycle as rvalid and gnt: the in-flight response and the newly granted stale response are both discarded; no stale PC ever appears on instr_pc_o.
- Error on the response for PC 0x20: entry has instr_err_o=1 and issuing stops (ERR_HOLD); redirect to 0x40 resumes fetching at 0x40.
- IFB_BYPASS_EN defined, FIFO empty, ready=1: instr_valid_o is high in the same cycle as rvalid and count stays 0.

Source files
------------

// File: rtl/ifetch_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifetch_prefetch_buf_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic               err;
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } ifb_entry_t;

   typedef enum logic {
      RUN      = 1'b0,
      ERR_HOLD = 1'b1
   } ifb_state_t;

endpackage

// File: rtl/ifetch_prefetch_buf_fifo.sv
// ifb_fifo: synchronous DEPTH-entry FIFO with push/pop/flush; push into a full
// FIFO is accepted only together with a pop.
module ifb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: nothing is read until count says it was written.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Sequential instruction prefetcher with an in-order response FIFO and redirect flush.
// Optional macro IFB_BYPASS_EN: a response may reach the consumer in its own cycle.
module ifetch_prefetch_buf
   import ifetch_prefetch_buf_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   input  logic        ready_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_err_o,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;

   ifb_state_t  state;
   logic        run_en;
   logic [31:0] fetch_pc;
   logic        req_hold;
   logic        hold_stale;
   logic [31:0] hold_addr;
   logic [CW-1:0] discard;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] ent_count;
   logic [OW-1:0] occupancy;
   logic        ent_full, ent_empty, tag_full, tag_empty;
   logic        new_req, grant, stale_grant;
   logic        resp_live, drop_now, bypass, head_valid;
   logic        ent_push, ent_pop, tag_pop;
   logic [31:0] tag_pc;
   ifb_entry_t  rsp_entry, ent_head, head;

   // The tag queue holds one PC per granted request, so its count is the
   // outstanding counter; it is never flushed and stays aligned with the bus.
   assign occupancy = {1'b0, ent_count} + {1'b0, outstanding};
   assign new_req   = run_en && (state == RUN) && !ent_full && !tag_full &&
                      (occupancy < OW'(DEPTH));
   assign bus_req_o  = req_hold || new_req;
   assign bus_addr_o = req_hold ? hold_addr : fetch_pc;
   assign grant       = bus_req_o && bus_gnt_i;
   assign stale_grant = grant && req_hold && hold_stale;

   assign tag_pop   = bus_rvalid_i && !tag_empty;
   assign drop_now  = bus_rvalid_i && (discard != '0);
   assign resp_live = bus_rvalid_i && !redirect_i && (discard == '0);
   assign rsp_entry = '{err: bus_err_i, pc: tag_pc, instr: bus_rdata_i};

`ifdef IFB_BYPASS_EN
   assign bypass = resp_live && ent_empty;
`else
   assign bypass = 1'b0;
`endif

   assign head_valid = !ent_empty || bypass;
   assign head       = ent_empty ? rsp_entry : ent_head;
   assign ent_push   = resp_live && !(bypass && ready_i);
   assign ent_pop    = ready_i && !ent_empty;

   assign instr_valid_o = head_valid;
   assign instr_o       = head_valid ? head.instr : '0;
   assign instr_pc_o    = head_valid ? head.pc    : '0;
   assign instr_err_o   = head_valid && head.err;

   ifb_fifo #(.DEPTH(DEPTH), .W($bits(ifb_entry_t))) u_ent_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (redirect_i),
      .push      (ent_push),
      .push_data (rsp_entry),
      .pop       (ent_pop),
      .head      (ent_head),
      .full      (ent_full),
      .empty     (ent_empty),
      .count     (ent_count)
   );

   ifb_fifo #(.DEPTH(DEPTH), .W(32)) u_tag_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (1'b0),
      .push      (grant),
      .push_data (bus_addr_o),
      .pop       (tag_pop),
      .head      (tag_pc),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (outstanding)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= RUN;
         run_en     <= 1'b0;
         fetch_pc   <= RESET_PC;
         req_hold   <= 1'b0;
         hold_stale <= 1'b0;
         hold_addr  <= '0;
         discard    <= '0;
      end else begin
         run_en   <= 1'b1;
         req_hold <= bus_req_o && !bus_gnt_i;
         // An ungranted request keeps its address; a redirect marks it stale.
         if (bus_req_o && !bus_gnt_i) begin
            hold_addr  <= bus_addr_o;
            hold_stale <= (req_hold && hold_stale) || redirect_i;
         end else begin
            hold_stale <= 1'b0;
         end
         if (redirect_i) begin
            state    <= RUN;
            fetch_pc <= redirect_addr_i & 32'hFFFF_FFFC;
            discard  <= outstanding - CW'(bus_rvalid_i) + CW'(grant);
         end else begin
            if (grant && !stale_grant) fetch_pc <= fetch_pc + PC_STEP;
            discard <= discard + CW'(stale_grant) - CW'(drop_now);
            if (resp_live && bus_err_i) state <= ERR_HOLD;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Directed bench for ifetch_prefetch_buf: bus responder, expected-entry scoreboard, monitor.
module tb_ifetch_prefetch_buf;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_addr_i = '0;
   logic        ready_i = 1'b0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_err_o;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_gnt_i = 1'b0;
   logic        bus_rvalid_i = 1'b0;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_err_i = 1'b0;

   logic        gnt_en = 1'b0;
   logic        rsp_en = 1'b0;
   int          gnt_limit = 0;
   int          grant_cnt = 0;
   logic [31:0] err_addr = 32'h1;
   logic [31:0] rsp_addr;
   logic [31:0] gnt_q[$];
   logic [31:0] grant_log[$];
   logic [64:0] exp_q[$];
   logic [64:0] got;
   int          n_checks = 0;
   int          n_errors = 0;

   ifetch_prefetch_buf #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .ready_i         (ready_i),
      .instr_valid_o   (instr_valid_o),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_err_o     (instr_err_o),
      .bus_req_o       (bus_req_o),
      .bus_addr_o      (bus_addr_o),
      .bus_gnt_i       (bus_gnt_i),
      .bus_rvalid_i    (bus_rvalid_i),
      .bus_rdata_i     (bus_rdata_i),
      .bus_err_i       (bus_err_i)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bus responder ----------------
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[19:0], 12'h013};
   endfunction

   always @(negedge clk) begin
      if (rstn && bus_req_o && bus_gnt_i) begin
         n_checks++;
         if (bus_addr_o[1:0] !== 2'b00) begin
            n_errors++;
            $display("FAIL bus_addr_align: got %h required low bits 00", bus_addr_o);
         end
         gnt_q.push_back(bus_addr_o);
         grant_log.push_back(bus_addr_o);
         grant_cnt++;
      end
   end

   // Responses come one cycle after the grant, in order.
   always @(posedge clk) begin
      #2;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      bus_err_i    = 1'b0;
      bus_gnt_i    = rstn && gnt_en && (grant_cnt < gnt_limit);
      if (rstn && rsp_en && gnt_q.size() != 0) begin
         rsp_addr     = gnt_q.pop_front();
         bus_rvalid_i = 1'b1;
         bus_rdata_i  = instr_of(rsp_addr);
         bus_err_i    = (rsp_addr == err_addr);
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rstn && instr_valid_o && ready_i) begin
         got = {instr_err_o, instr_pc_o, instr_o};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: got err=%b pc=%h instr=%h, required no transfer",
                     instr_err_o, instr_pc_o, instr_o);
         end else if (got !== exp_q[0]) begin
            n_errors++;
            $display("FAIL entry: got err=%b pc=%h instr=%h, required err=%b pc=%h instr=%h",
                     got[64], got[63:32], got[31:0], exp_q[0][64], exp_q[0][63:32], exp_q[0][31:0]);
            void'(exp_q.pop_front());
         end else begin
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] log_at(input int i);
      if (i < grant_log.size()) return grant_log[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic expect_entry(input logic err, input logic [31:0] pc, input logic [31:0] instr);
      exp_q.push_back({err, pc, instr});
   endtask

   // Leaves the bench at cycle A (#1 after the first edge with rstn high).
   task automatic do_reset(input int limit, input logic rdy, input logic rsp, input logic [31:0] eaddr);
      @(posedge clk);
      #1;
      rstn       = 1'b0;
      redirect_i = 1'b0;
      ready_i    = rdy;
      gnt_en     = 1'b1;
      rsp_en     = rsp;
      gnt_limit  = limit;
      err_addr   = eaddr;
      exp_q.delete();
      gnt_q.delete();
      grant_log.delete();
      grant_cnt  = 0;
      @(negedge clk);
      check("reset_ctrl", {bus_req_o, instr_valid_o, instr_err_o}, 3'b000);
      check("reset_data", {instr_o, instr_pc_o}, 64'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic pulse_redirect(input logic [31:0] addr);
      redirect_i      = 1'b1;
      redirect_addr_i = addr;
      tick();
      redirect_i      = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      tick(6);
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      // T1: streaming with ready=1
      do_reset(4, 1'b1, 1'b1, 32'h1);
      expect_entry(1'b0, 32'h0000_0000, 32'h0000_0013);
      expect_entry(1'b0, 32'h0000_0004, 32'h0000_4013);
      expect_entry(1'b0, 32'h0000_0008, 32'h0000_8013);
      expect_entry(1'b0, 32'h0000_000C, 32'h0000_C013);
      tick(2);
      @(negedge clk);
`ifdef IFB_BYPASS_EN
      check("t1_bypass_same_cycle", {bus_rvalid_i, instr_valid_o, instr_pc_o}, {1'b1, 1'b1, 32'h0});
      tick();
      @(negedge clk);
      check("t1_bypass_count", dut.ent_count, 0);
`else
      check("t1_no_bypass", {bus_rvalid_i, instr_valid_o}, 2'b10);
      tick();
      @(negedge clk);
      check("t1_latency", {instr_valid_o, instr_pc_o}, {1'b1, 32'h0});
`endif
      drain("t1_drain");
      check("t1_addr0", log_at(0), 32'h0);
      check("t1_addr1", log_at(1), 32'h4);
      check("t1_addr2", log_at(2), 32'h8);
      check("t1_addr3", log_at(3), 32'hC);

      // T2: ready=0 fills the FIFO and throttles requests
      do_reset(4, 1'b0, 1'b1, 32'h1);
      expect_entry(1'b0, 32'h0000_0000, 32'h0000_0013);
      expect_entry(1'b0, 32'h0000_0004, 32'h0000_4013);
      expect_entry(1'b0, 32'h0000_0008, 32'h0000_8013);
      expect_entry(1'b0, 32'h0000_000C, 32'h0000_C013);
      tick(4);
      @(negedge clk);
      check("t2_full_stall", {bus_req_o, instr_valid_o, instr_pc_o}, {1'b0, 1'b1, 32'h0});
      check("t2_grants_full", grant_cnt, 2);
      tick();
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      tick(6);
      @(negedge clk);
      check("t2_one_new_req", grant_cnt, 3);
      check("t2_req_low", bus_req_o, 1'b0);
      check("t2_addr2", log_at(2), 32'h8);
      tick();
      ready_i = 1'b1;
      drain("t2_drain");

      // T3: redirect with two requests in flight
      do_reset(4, 1'b1, 1'b0, 32'h1);
      pulse_redirect(32'h0000_0010);
      expect_entry(1'b0, 32'h0000_0100, 32'h0010_0013);
      expect_entry(1'b0, 32'h0000_0104, 32'h0010_4013);
      tick(2);
      redirect_i      = 1'b1;
      redirect_addr_i = 32'h0000_0103;
      @(negedge clk);
      check("t3_two_outstanding", {bus_req_o, 32'(grant_cnt)}, {1'b0, 32'd2});
      tick();
      redirect_i = 1'b0;
      rsp_en     = 1'b1;
      drain("t3_drain");
      check("t3_addr1", log_at(1), 32'h14);
      check("t3_addr2", log_at(2), 32'h100);

      // T4: redirect in the same cycle as rvalid and grant
      do_reset(4, 1'b1, 1'b1, 32'h1);
      expect_entry(1'b0, 32'h0000_0200, 32'h0020_0013);
      expect_entry(1'b0, 32'h0000_0204, 32'h0020_4013);
      tick(2);
      redirect_i      = 1'b1;
      redirect_addr_i = 32'h0000_0200;
      @(negedge clk);
      check("t4_collision", {bus_rvalid_i, bus_req_o, bus_gnt_i, instr_valid_o}, 4'b1110);
      tick();
      redirect_i = 1'b0;
      drain("t4_drain");
      check("t4_addr2", log_at(2), 32'h200);

      // T5: error response stops fetching until a redirect
      do_reset(4, 1'b1, 1'b1, 32'h20);
      pulse_redirect(32'h0000_0020);
      expect_entry(1'b1, 32'h0000_0020, 32'h0002_0013);
      expect_entry(1'b0, 32'h0000_0024, 32'h0002_4013);
      expect_entry(1'b0, 32'h0000_0040, 32'h0004_0013);
      expect_entry(1'b0, 32'h0000_0044, 32'h0004_4013);
      tick(6);
      @(negedge clk);
      check("t5_err_hold", {bus_req_o, 32'(grant_cnt)}, {1'b0, 32'd2});
      check("t5_err_hold_drained", exp_q.size(), 2);
      tick();
      pulse_redirect(32'h0000_0040);
      drain("t5_drain");
      check("t5_addr2", log_at(2), 32'h40);

      // T6: asynchronous reset in mid-operation
      do_reset(8, 1'b0, 1'b1, 32'h1);
      tick(4);
      @(negedge clk);
      check("t6_valid_before", {instr_valid_o, instr_pc_o}, {1'b1, 32'h0});
      #2;
      rstn = 1'b0;
      exp_q.delete();
      #1;
      check("t6_async_ctrl", {bus_req_o, instr_valid_o, instr_err_o}, 3'b000);
      check("t6_async_data", {instr_o, instr_pc_o}, 64'h0);
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
